// File: rtl/mem_stage.sv
// mem_stage: registers execute results and runs Lw/Sw over a req/ack bus.
// Optional misaligned-access trap: define MEM_ALIGN_CHECK_EN.
`ifndef Lw
`define Lw 6'b100011
`endif
`ifndef Sw
`define Sw 6'b101011
`endif

module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  op,
    input  logic [31:0] memAddr,
    input  logic [31:0] memData,
    input  logic [31:0] regcData,
    input  logic        regcWrite,
    input  logic [4:0]  regcAddr,
    output logic        wb_valid,
    output logic [31:0] wb_regcData,
    output logic        wb_regcWrite,
    output logic [4:0]  wb_regcAddr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        bus_err,
    output logic        align_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] TO = TIMEOUT[7:0];

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_inc;
    logic       accept, is_lw, is_sw, is_mem, timeout;

    assign ex_ready = (state == IDLE) && !rst;
    assign accept   = ex_valid && ex_ready;
    assign is_lw    = (op == `Lw);
    assign is_sw    = (op == `Sw);
    assign is_mem   = is_lw || is_sw;
    // saturating: never wraps back under TIMEOUT
    assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign timeout  = (cnt_inc >= TO);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = is_mem && (memAddr[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef MEM_ALIGN_CHECK_EN
                if (accept && is_mem && !misalign) state_nxt = ACCESS;
`else
                if (accept && is_mem) state_nxt = ACCESS;
`endif
            end
            ACCESS: if (dm_ack || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_regcData  <= 32'd0;
            wb_regcWrite <= 1'b0;
            wb_regcAddr  <= 5'd0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= 32'd0;
            dm_wdata     <= 32'd0;
            bus_err      <= 1'b0;
            cnt          <= 8'd0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err    <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
            case (state)
                IDLE: if (accept) begin
                    wb_regcAddr <= regcAddr;
                    if (!is_mem) begin
                        wb_regcData  <= regcData;
                        wb_regcWrite <= regcWrite;
                        wb_valid     <= 1'b1;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (misalign) begin
                        wb_regcWrite <= 1'b0;
                        wb_valid     <= 1'b1;
                        align_err    <= 1'b1;
                    end
`endif
                    else begin
                        wb_regcWrite <= regcWrite;
                        dm_req       <= 1'b1;
                        dm_we        <= is_sw;
                        dm_addr      <= memAddr;
                        dm_wdata     <= memData;
                        cnt          <= 8'd0;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        dm_req   <= 1'b0;
                        wb_valid <= 1'b1;
                        if (dm_we) wb_regcWrite <= 1'b0;
                        else       wb_regcData  <= dm_rdata;
                    end else if (timeout) begin
                        dm_req       <= 1'b0;
                        bus_err      <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_regcWrite <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
